// File: rtl/ub_read_streamer.sv
// ub_read_streamer: reads a run of consecutive unified-buffer words starting
// at a base address. The words are streamed out over a valid/ready interface,
// with a 3-entry FIFO that absorbs SRAM read latency and backpressure.
module ub_read_streamer #(
  parameter int ADDRESSSIZE = 10,
  parameter int WORDSIZE    = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDRESSSIZE-1:0] base_addr,
  input  logic [ADDRESSSIZE:0]   length,
  output logic                   busy,
  output logic                   done,
  output logic                   ub_write_enable,
  output logic [ADDRESSSIZE-1:0] ub_address,
  input  logic [WORDSIZE-1:0]    ub_data_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORDSIZE-1:0]    out_data,
  output logic                   out_last
);

  localparam int DEPTH = 3;
  localparam logic [ADDRESSSIZE:0]   ONE_LEN  = 1;
  localparam logic [ADDRESSSIZE-1:0] ONE_ADDR = 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

  state_e                 state_q, state_d;
  logic [ADDRESSSIZE-1:0] base_q, base_d;
  logic [ADDRESSSIZE-1:0] issued_q, issued_d;
  logic [ADDRESSSIZE:0]   remaining_q, remaining_d;
  logic [ADDRESSSIZE-1:0] addr_q, addr_d;
  logic                   pending_q, pending_d;
  logic                   pend_last_q, pend_last_d;
  logic [1:0]             wr_ptr_q, wr_ptr_d;
  logic [1:0]             rd_ptr_q, rd_ptr_d;
  logic [1:0]             count_q, count_d;

  logic [WORDSIZE-1:0]    fifo_data_q [DEPTH];
  logic                   fifo_last_q [DEPTH];

  logic issue;
  logic push;
  logic pop;
  logic head_last;

  // Pointer advance for a 3-entry ring.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Issue a read only if the word has a guaranteed FIFO slot.
  // The in-flight read counts as occupied.
  assign issue = (state_q == S_RUN) && (remaining_q != '0) &&
                 (({1'b0, count_q} + {2'b00, pending_q}) < 3'd3);
  assign push      = pending_q;
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign head_last = fifo_last_q[rd_ptr_q];

  assign busy            = (state_q == S_RUN);
  assign done            = (state_q == S_FIN);
  assign ub_write_enable = 1'b0;
  // The address is live in the issue cycle, so the data returns one cycle
  // later. When no read is issued, the last issued address is held.
  assign ub_address      = issue ? (base_q + issued_q) : addr_q;

  // The FIFO storage is not reset, so the head is masked while empty.
  // This keeps out_data and out_last at 0 out of reset.
  assign out_data = out_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign out_last = out_valid && head_last;

  // Next-state logic for the FSM and the transfer counters.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one unassigned and infers a latch.
    state_d     = state_q;
    base_d      = base_q;
    issued_d    = issued_q;
    remaining_d = remaining_q;
    case (state_q)
      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        if (start) begin
          base_d      = base_addr;
          issued_d    = '0;
          remaining_d = length;
          state_d     = (length == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          issued_d    = issued_q + ONE_ADDR;
          remaining_d = remaining_q - ONE_LEN;
        end
        if (pop && head_last) state_d = S_FIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read-pipeline and FIFO bookkeeping.
  always_comb begin
    addr_d      = ub_address;
    pending_d   = issue;
    pend_last_d = issue && (remaining_q == ONE_LEN);
    wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset. A reset aborts any transfer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      issued_q    <= '0;
      remaining_q <= '0;
      addr_q      <= '0;
      pending_q   <= 1'b0;
      pend_last_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issued_q    <= issued_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      pending_q   <= pending_d;
      pend_last_q <= pend_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage captures the returning SRAM word.
  always_ff @(posedge clk) begin
    // NOTE: the data storage has no reset. Validity comes from count_q, which is reset.
    if (push) begin
      fifo_data_q[wr_ptr_q] <= ub_data_out;
      fifo_last_q[wr_ptr_q] <= pend_last_q;
    end
  end

endmodule
